pipe_gen: RTL and testbench
===========================

Name: pipe_gen

Overview:
- Generates the scrolling pipe field for Flappy Bird and drives the `pipe` column that the crash detector consumes.
- Holds a COLS-deep column shift chain that advances one column per `tick`.
- Emits empty columns and wall columns in alternation; each wall has a pseudo-random gap.
- Outputs the entering column for the LED matrix and the column under the bird.

Parameters:
- COLS, 8: number of columns in the shift chain; col[COLS-1] is the entry (right edge), col[0] the left edge.
- BIRD_COL, 1: chain index presented on `pipe`.
- GAP_H, 3: gap height in rows; legal range 1..6.
- PIPE_W, 1: wall width in columns; must be at least 1.
- SPACING, 3: empty columns between walls; must be at least 1.
- MIN_SPACING, 1: floor for spacing when SPACING_RAMP_EN is defined.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- active  input  1  game running; low clears the field synchronously
- tick  input  1  single-cycle scroll strobe
- new_col  output  8  col[COLS-1], the column currently entering
- pipe  output  8  col[BIRD_COL], the column fed to the crash detector
- walls  output  8  count of walls spawned; saturates at 255

Behaviour:
- Column format: bit 7 is the top row, bit 0 the ground row. Bit 0 is always 0 in every column.
- Wall pattern: bits 7..1 are 1, except rows gap_lo .. gap_lo+GAP_H-1, which are 0.
- LFSR: 8 bits, seed 8'hA5, polynomial x^8+x^6+x^5+x^4+1.
  - Steps every clk cycle, regardless of `active` or `tick`.
  - Reset reloads the seed only; the `~active` clear does not touch it.
- Gap position: gap_lo = 1 + (lfsr[2:0] mod (8-GAP_H)).
  - Latched on the SPACE->WALL transition.
  - All PIPE_W columns of one wall share the same gap.
- Async reset: all columns = 0, state IDLE, cnt = 0, walls = 0, LFSR = seed. Therefore new_col = pipe = 8'h00 and walls = 0.
- Sync clear: while `~active`, everything clears exactly as on reset except the LFSR.
- FSM:
  - IDLE: `tick` is ignored. If `active`, the next state is SPACE with cnt = SPACING.
  - SPACE: on `tick`, shift in 8'h00 and decrement cnt. If cnt was 1, go to WALL, load cnt = PIPE_W, latch gap_lo, and increment walls (saturating).
  - WALL: on `tick`, shift in the wall pattern and decrement cnt. If cnt was 1, go to SPACE and load cnt = spacing.
- Shift rule: on an accepted `tick`, col[i] <= col[i+1] for i < COLS-1, and col[COLS-1] <= the generated column.
- No `tick`: the chain and cnt hold; only the LFSR steps.
- Latency:
  - The generated column appears on new_col one cycle after the accepting `tick`.
  - It reaches `pipe` after (COLS-1-BIRD_COL) further ticks.
- `tick` in the same cycle as `~active` or reset: the clear wins and the `tick` is dropped.
- `active` falling mid-wall: the field clears next cycle; the next rise restarts at IDLE.
- Outputs are direct register taps with no combinational path from the inputs.

Optional Feature:
- Macro: SPACING_RAMP_EN.
- Defined:
  - A register cur_sp resets and clears to SPACING.
  - On each WALL->SPACE transition, cnt is loaded from cur_sp, after which cur_sp decrements if cur_sp > MIN_SPACING.
  - cur_sp never drops below MIN_SPACING.
- Undefined: cnt always reloads SPACING, and the cur_sp register is not built.

Test Plan:
- Reset then hold: reset=1 with arbitrary `tick` -> new_col = pipe = 8'h00 and walls = 0.
- First wall: `active` rises, wait one clk, then tick x3 -> new_col = 00 after each; 4th tick -> new_col is one of {F0, E2, C6, 8E, 1E} and walls = 1.
- Bird column arrival: continue ticks -> the same wall value appears on `pipe` exactly 6 ticks after it entered new_col. Columns between walls read 00, and every bit 0 reads 0.
- Idle clock: no `tick` for 20 cycles mid-field -> new_col and pipe unchanged.
- Clear mid-field: `active`=0 for one cycle while a wall sits at col 4 -> all columns 00 and walls = 0. After re-activation, 4 ticks are needed before the first wall again.
- Saturation and ramp (macro defined): run 300 walls -> walls stays at 255. Gaps between successive walls measure 3, 2, 1, 1, 1 empty columns (SPACING=3, MIN_SPACING=1).

Source files
------------

// File: rtl/pipe_gen.sv
// Scrolling pipe-field generator: a COLS-deep column chain that receives empty and wall
// columns in turn, with a pseudo-random gap in each wall. Optional macro: SPACING_RAMP_EN.
module pipe_gen #(
  parameter int COLS        = 8,
  parameter int BIRD_COL    = 1,
  parameter int GAP_H       = 3,
  parameter int PIPE_W      = 1,
  parameter int SPACING     = 3,
  parameter int MIN_SPACING = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       active,
  input  logic       tick,
  output logic [7:0] new_col,
  output logic [7:0] pipe,
  output logic [7:0] walls
);

  localparam int GMOD = 8 - GAP_H;

  typedef enum logic [1:0] {IDLE, SPACE, WALL} state_t;

  state_t                r_state, w_state_nxt;
  logic [COLS-1:0][7:0]  r_col;
  logic [7:0]            r_cnt, w_cnt_nxt;
  logic [7:0]            r_walls, w_walls_nxt;
  logic [7:0]            r_lfsr;
  logic [2:0]            r_gap, w_gap_nxt, w_gap_new;
  logic [7:0]            w_wall, w_gen, w_reload;
  logic                  w_shift;

`ifdef SPACING_RAMP_EN
  logic [7:0]            r_sp, w_sp_nxt;
  assign w_reload = r_sp;
`else
  assign w_reload = 8'(SPACING);
`endif

  // Free-running Fibonacci LFSR, x^8+x^6+x^5+x^4+1; only reset reseeds it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_lfsr <= 8'hA5;
    else       r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end

  assign w_gap_new = 3'(1 + (32'(r_lfsr[2:0]) % GMOD));

  always_comb begin
    w_wall = '0;
    for (int i = 1; i < 8; i++)
      w_wall[i] = ~((i >= int'(r_gap)) && (i < int'(r_gap) + GAP_H));
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_walls_nxt = r_walls;
    w_gap_nxt   = r_gap;
    w_shift     = 1'b0;
    w_gen       = 8'h00;
`ifdef SPACING_RAMP_EN
    w_sp_nxt    = r_sp;
`endif
    case (r_state)
      IDLE: begin
        w_state_nxt = SPACE;
        w_cnt_nxt   = 8'(SPACING);
      end
      SPACE: if (tick) begin
        w_shift   = 1'b1;
        w_cnt_nxt = r_cnt - 8'd1;
        if (r_cnt == 8'd1) begin
          w_state_nxt = WALL;
          w_cnt_nxt   = 8'(PIPE_W);
          w_gap_nxt   = w_gap_new;
          if (r_walls != 8'hFF) w_walls_nxt = r_walls + 8'd1;
        end
      end
      WALL: if (tick) begin
        w_shift   = 1'b1;
        w_gen     = w_wall;
        w_cnt_nxt = r_cnt - 8'd1;
        if (r_cnt == 8'd1) begin
          w_state_nxt = SPACE;
          w_cnt_nxt   = w_reload;
`ifdef SPACING_RAMP_EN
          if (r_sp > 8'(MIN_SPACING)) w_sp_nxt = r_sp - 8'd1;
`endif
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Inactive clears the field synchronously and outranks any tick in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_col   <= '0;
      r_cnt   <= '0;
      r_walls <= '0;
      r_gap   <= 3'd1;
    end else if (!active) begin
      r_state <= IDLE;
      r_col   <= '0;
      r_cnt   <= '0;
      r_walls <= '0;
      r_gap   <= 3'd1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_walls <= w_walls_nxt;
      r_gap   <= w_gap_nxt;
      if (w_shift) begin
        for (int i = 0; i < COLS - 1; i++) r_col[i] <= r_col[i+1];
        r_col[COLS-1] <= w_gen;
      end
    end
  end

`ifdef SPACING_RAMP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_sp <= 8'(SPACING);
    else if (!active) r_sp <= 8'(SPACING);
    else              r_sp <= w_sp_nxt;
  end
`endif

  assign new_col = r_col[COLS-1];
  assign pipe    = r_col[BIRD_COL];
  assign walls   = r_walls;

endmodule

// File: tb/tb_pipe_gen.sv
// Directed + randomized bench for pipe_gen against a queue-based column-sequence model.
module tb_pipe_gen;
  localparam int COLS = 8, BIRD_COL = 1, GAP_H = 3, PIPE_W = 1, SPACING = 3, MIN_SP = 1;

  logic       clk = 1'b0, reset = 1'b1, active = 1'b0, tick = 1'b0;
  logic [7:0] new_col, pipe, walls;
  int         checks = 0, failures = 0;

  pipe_gen dut (
    .clk(clk), .reset(reset), .active(active), .tick(tick),
    .new_col(new_col), .pipe(pipe), .walls(walls)
  );

  always #5 clk = ~clk;

  // Reference LFSR: taps 8,6,5,4 -> feedback from bits 7,5,4,3.
  logic [7:0] m_lfsr;
  always @(posedge clk or posedge reset)
    if (reset) m_lfsr <= 8'hA5;
    else       m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};

  logic [7:0] m_col [COLS];
  bit         q[$];          // pending column kinds: 0 = empty, 1 = wall
  int         m_grp, m_walls, m_gap;
  bit         m_armed, m_wall_in;

  function automatic logic [7:0] wall_of(int g);
    int m;
    m = ((1 << GAP_H) - 1) << g;
    return 8'hFE & ~8'(m);
  endfunction

  function automatic int spacing_of(int n);
`ifdef SPACING_RAMP_EN
    int v;
    if (n == 0) return SPACING;
    v = SPACING - (n - 1);
    return (v < MIN_SP) ? MIN_SP : v;
`else
    return SPACING + 0 * n;
`endif
  endfunction

  task automatic model_clear();
    foreach (m_col[i]) m_col[i] = 8'h00;
    q.delete();
    m_grp = 0; m_walls = 0; m_armed = 0;
  endtask

  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_outs();
    chk("new_col", new_col, m_col[COLS-1]);
    chk("pipe", pipe, m_col[BIRD_COL]);
    chk("walls", walls, 8'(m_walls));
  endtask

  task automatic chk_legal();
    bit ok = 0;
    for (int g = 1; g <= 8 - GAP_H; g++) if (new_col === wall_of(g)) ok = 1;
    checks++;
    assert (ok) else begin
      failures++;
      $error("FAIL wall_legal got=%h exp=one_of_legal_patterns", new_col);
    end
  endtask

  // One clock: inputs set at negedge, model advanced, outputs checked next negedge.
  task automatic cyc(input bit a, input bit t);
    bit         k;
    logic [7:0] gen;
    active = a; tick = t; m_wall_in = 0;
    if (!a) model_clear();
    else if (!m_armed) m_armed = 1;
    else if (t) begin
      if (q.size() < 2) begin
        int sp;
        sp = spacing_of(m_grp);
        m_grp++;
        repeat (sp) q.push_back(1'b0);
        repeat (PIPE_W) q.push_back(1'b1);
      end
      k = q.pop_front();
      if (!k) begin
        gen = 8'h00;
        if (q[0]) begin
          m_gap = 1 + (int'(m_lfsr[2:0]) % (8 - GAP_H));
          if (m_walls < 255) m_walls++;
        end
      end else begin
        gen = wall_of(m_gap);
        m_wall_in = 1;
      end
      for (int i = 0; i < COLS - 1; i++) m_col[i] = m_col[i+1];
      m_col[COLS-1] = gen;
    end
    @(posedge clk);
    @(negedge clk);
    tick = 1'b0;
    check_outs();
    if (m_wall_in) chk_legal();
  endtask

  initial begin
    bit found;
    model_clear();
    // Reset with a tick held high.
    reset = 1'b1; tick = 1'b1;
    repeat (3) @(negedge clk);
    check_outs();
    reset = 1'b0; tick = 1'b0;
    cyc(0, 1);
    // Activation cycle drops its tick, then the first wall arrives on the 4th tick.
    cyc(1, 1);
    repeat (14) cyc(1, 1);
    // Idle clock: field holds.
    repeat (20) cyc(1, 0);
    // Clear while a wall sits at col 4.
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_col[4] != 8'h00) found = 1;
      else cyc(1, 1);
    end
    checks++;
    assert (found) else begin
      failures++;
      $error("FAIL col4_wall got=not_found exp=found");
    end
    cyc(0, 1);
    cyc(1, 1);
    repeat (10) cyc(1, 1);
    // Randomized play with occasional deactivation.
    repeat (600) cyc(($urandom % 64) != 0, 1'($urandom % 2));
    // Async reset mid-field, concurrent with a tick.
    @(negedge clk);
    reset = 1'b1; tick = 1'b1;
    model_clear();
    #1 check_outs();
    @(negedge clk);
    reset = 1'b0; tick = 1'b0;
    cyc(1, 0);
    // Saturation run.
    repeat (1500) cyc(1, 1);
    chk("walls_sat", walls, 8'hFF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
